// File: rtl/lsu_sequencer.sv
// Load/store sequencer: captures one decoded memory instruction, runs the
// request/response handshake with data memory and stalls the PC meanwhile.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        store_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_result,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_next;
  logic [2:0]  f3_p0;
  logic [1:0]  off_p0;
  logic        req_any;
  logic        illegal;
  logic        misaligned;
  logic        bad;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // Decode-time validation; illegal encodings take priority over misalignment.
  assign req_any    = load_req | store_req;
  assign illegal    = (load_req & store_req)
                    | (load_req & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
                    | (store_req & (funct3[2] | (funct3 == 3'b011)));
  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0])
                    | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign bad        = illegal | misaligned;
  assign tmo_next   = tmo_cnt + 8'd1;

  assign stall = ((state == IDLE) & req_any & ~bad) | (state == REQ) | (state == WAIT_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      f3_p0         <= 3'd0;
      off_p0        <= 2'd0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_be        <= 4'd0;
      mem_wdata     <= 32'd0;
      done          <= 1'b0;
      load_result   <= 32'd0;
      fault         <= 1'b0;
      fault_code    <= 2'b00;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (bad) begin
              fault      <= 1'b1;
              fault_code <= illegal ? 2'b10 : 2'b01;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= store_req;
              mem_addr      <= {addr[31:2], 2'b00};
              mem_be        <= byte_en(funct3, addr[1:0]);
              mem_wdata     <= lane_data(funct3, store_data);
              f3_p0         <= funct3;
              off_p0        <= addr[1:0];
              tmo_cnt       <= 8'd0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tmo_cnt       <= 8'd0;
            if (mem_we) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end else if (tmo_next == TMO) begin
            mem_req_valid <= 1'b0;
            fault         <= 1'b1;
            fault_code    <= 2'b11;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            load_result <= load_extend(f3_p0, off_p0, mem_rdata);
            done        <= 1'b1;
            state       <= DONE;
          end else if (tmo_next == TMO) begin
            fault      <= 1'b1;
            fault_code <= 2'b11;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: stores, loads, faults, timeouts and reset.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req, store_req;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        stall, done, fault;
  logic [31:0] load_result;
  logic [1:0]  fault_code;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .store_req(store_req),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .stall(stall), .done(done), .load_result(load_result),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 0; store_req = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    step(); step();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({mem_req_valid, mem_we, done, fault, stall, fault_code, mem_be, mem_addr, mem_wdata, load_result} !== '0) begin
      $display("FAIL reset_state got %h exp 0", {mem_req_valid, mem_we, done, fault, stall, fault_code, mem_be, mem_addr, mem_wdata, load_result});
      tests_failed++;
    end
  endtask

  // Store with ready asserted in the REQ cycle: done in cycle 2.
  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    store_req = 1; funct3 = f3; addr = a; store_data = d; mem_req_ready = 1;
    #1;
    tests_run++;
    if ({stall, mem_req_valid} !== 2'b10) begin
      $display("FAIL %s_c0 stall/valid got %b exp 10", name, {stall, mem_req_valid}); tests_failed++;
    end
    step();
    store_req = 0; #1;
    tests_run++;
    if ({mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata, stall, done} !== {2'b11, exp_addr, exp_be, exp_wd, 2'b10}) begin
      $display("FAIL %s_req got %h exp %h", name, {mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata, stall, done},
               {2'b11, exp_addr, exp_be, exp_wd, 2'b10});
      tests_failed++;
    end
    step(); mem_req_ready = 0; #1;
    tests_run++;
    if ({done, stall, mem_req_valid} !== 3'b100) begin
      $display("FAIL %s_done got %b exp 100", name, {done, stall, mem_req_valid}); tests_failed++;
    end
    step(); #1;
    tests_run++;
    if ({done, stall} !== 2'b00) begin
      $display("FAIL %s_after got %b exp 00", name, {done, stall}); tests_failed++;
    end
  endtask

  // Load with ready in REQ and response one cycle later: done in cycle 3.
  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_res);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    load_req = 1; funct3 = f3; addr = a; #1;
    tests_run++;
    if (stall !== 1'b1) begin
      $display("FAIL %s_c0 stall got %b exp 1", name, stall); tests_failed++;
    end
    step(); load_req = 0; mem_req_ready = 1; #1;
    tests_run++;
    if ({mem_req_valid, mem_we, mem_addr, mem_be, stall} !== {2'b10, exp_addr, exp_be, 1'b1}) begin
      $display("FAIL %s_req got %h exp %h", name, {mem_req_valid, mem_we, mem_addr, mem_be, stall}, {2'b10, exp_addr, exp_be, 1'b1});
      tests_failed++;
    end
    step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = rd; #1;
    tests_run++;
    if ({mem_req_valid, stall, done} !== 3'b010) begin
      $display("FAIL %s_wait got %b exp 010", name, {mem_req_valid, stall, done}); tests_failed++;
    end
    step(); mem_rsp_valid = 0; mem_rdata = 32'h0; #1;
    tests_run++;
    if ({done, stall, load_result} !== {2'b10, exp_res}) begin
      $display("FAIL %s_done got %h exp %h", name, {done, stall, load_result}, {2'b10, exp_res}); tests_failed++;
    end
    step(); #1;
    tests_run++;
    if ({done, load_result} !== {1'b0, exp_res}) begin
      $display("FAIL %s_hold got %h exp %h", name, {done, load_result}, {1'b0, exp_res}); tests_failed++;
    end
  endtask

  task automatic test_fault(input string name, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] exp_code);
    load_req = ld; store_req = st; funct3 = f3; addr = a; mem_req_ready = 1; #1;
    tests_run++;
    if (stall !== 1'b0) begin
      $display("FAIL %s_c0 stall got %b exp 0", name, stall); tests_failed++;
    end
    step(); load_req = 0; store_req = 0; #1;
    tests_run++;
    if ({fault, fault_code, mem_req_valid, stall} !== {1'b1, exp_code, 2'b00}) begin
      $display("FAIL %s_c1 got %b exp %b", name, {fault, fault_code, mem_req_valid, stall}, {1'b1, exp_code, 2'b00});
      tests_failed++;
    end
    step(); mem_req_ready = 0; #1;
    tests_run++;
    if ({fault, fault_code, mem_req_valid} !== {1'b0, exp_code, 1'b0}) begin
      $display("FAIL %s_c2 got %b exp %b", name, {fault, fault_code, mem_req_valid}, {1'b0, exp_code, 1'b0});
      tests_failed++;
    end
  endtask

  // lw accepted, then no response: four WAIT_RSP cycles, timeout, then a normal lw.
  task automatic test_timeout_rsp();
    load_req = 1; funct3 = 3'b010; addr = 32'h300; #1;
    step(); load_req = 0; mem_req_ready = 1; #1;
    step(); mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({stall, fault, done} !== 3'b100) begin
        $display("FAIL tmo_rsp_wait%0d got %b exp 100", i, {stall, fault, done}); tests_failed++;
      end
      step();
    end
    #1;
    tests_run++;
    if ({fault, fault_code, stall, done, mem_req_valid} !== 6'b111000) begin
      $display("FAIL tmo_rsp_fire got %b exp 111000", {fault, fault_code, stall, done, mem_req_valid}); tests_failed++;
    end
    step(); #1;
    tests_run++;
    if ({fault, done, stall} !== 3'b000) begin
      $display("FAIL tmo_rsp_after got %b exp 000", {fault, done, stall}); tests_failed++;
    end
    test_load("lw_after_tmo", 3'b010, 32'h400, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);
  endtask

  // Store never accepted: request dropped after four REQ cycles.
  task automatic test_timeout_req();
    store_req = 1; funct3 = 3'b010; addr = 32'h500; store_data = 32'h1; mem_req_ready = 0; #1;
    step(); store_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({mem_req_valid, stall, fault} !== 3'b110) begin
        $display("FAIL tmo_req_wait%0d got %b exp 110", i, {mem_req_valid, stall, fault}); tests_failed++;
      end
      step();
    end
    #1;
    tests_run++;
    if ({fault, fault_code, mem_req_valid, stall, done} !== 6'b111000) begin
      $display("FAIL tmo_req_fire got %b exp 111000", {fault, fault_code, mem_req_valid, stall, done}); tests_failed++;
    end
    step();
  endtask

  // A new store held through DONE is only accepted once back in IDLE.
  task automatic test_back_to_back();
    store_req = 1; funct3 = 3'b010; addr = 32'h600; store_data = 32'h11111111; mem_req_ready = 1; #1;
    step(); step();
    addr = 32'h604; store_data = 32'h22222222; #1;
    tests_run++;
    if ({done, stall} !== 2'b10) begin
      $display("FAIL b2b_done got %b exp 10", {done, stall}); tests_failed++;
    end
    step(); #1;
    tests_run++;
    if ({stall, mem_req_valid, done} !== 3'b100) begin
      $display("FAIL b2b_accept got %b exp 100", {stall, mem_req_valid, done}); tests_failed++;
    end
    step(); store_req = 0; #1;
    tests_run++;
    if ({mem_req_valid, mem_addr, mem_wdata} !== {1'b1, 32'h604, 32'h22222222}) begin
      $display("FAIL b2b_req got %h exp %h", {mem_req_valid, mem_addr, mem_wdata}, {1'b1, 32'h604, 32'h22222222});
      tests_failed++;
    end
    step(); mem_req_ready = 0; #1;
    tests_run++;
    if (done !== 1'b1) begin
      $display("FAIL b2b_done2 got %b exp 1", done); tests_failed++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    load_req = 1; funct3 = 3'b010; addr = 32'h700; #1;
    step(); load_req = 0; mem_req_ready = 1; #1;
    step(); mem_req_ready = 0; rst = 1; #1;
    step(); rst = 0; mem_rsp_valid = 1; mem_rdata = 32'h12345678; #1;
    tests_run++;
    if ({mem_req_valid, mem_we, done, fault, stall, fault_code, mem_be, mem_addr, mem_wdata, load_result} !== '0) begin
      $display("FAIL rst_mid got %h exp 0", {mem_req_valid, mem_we, done, fault, stall, fault_code, mem_be, mem_addr, mem_wdata, load_result});
      tests_failed++;
    end
    step(); mem_rsp_valid = 0; #1;
    tests_run++;
    if ({load_result, done, stall} !== 34'd0) begin
      $display("FAIL rst_late_rsp got %h exp 0", {load_result, done, stall}); tests_failed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    test_store("sb", 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    test_store("sh", 3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
    test_load("lb",  3'b000, 32'h202, 32'h80F07F01, 4'b0100, 32'hFFFFFFF0);
    test_load("lbu", 3'b100, 32'h202, 32'h80F07F01, 4'b0100, 32'h000000F0);
    test_load("lh",  3'b001, 32'h202, 32'h80F07F01, 4'b1100, 32'hFFFF80F0);
    test_load("lhu", 3'b101, 32'h202, 32'h80F07F01, 4'b1100, 32'h000080F0);
    test_load("lw",  3'b010, 32'h200, 32'h80F07F01, 4'b1111, 32'h80F07F01);
    test_load("lb1", 3'b000, 32'h201, 32'h80F07F01, 4'b0010, 32'h0000007F);
    test_fault("lw_mis",   1'b1, 1'b0, 3'b010, 32'h201, 2'b01);
    test_fault("sh_mis",   1'b0, 1'b1, 3'b001, 32'h101, 2'b01);
    test_fault("ld_f011",  1'b1, 1'b0, 3'b011, 32'h200, 2'b10);
    test_fault("st_f100",  1'b0, 1'b1, 3'b100, 32'h200, 2'b10);
    test_fault("both",     1'b1, 1'b1, 3'b010, 32'h200, 2'b10);
    test_timeout_rsp();
    test_timeout_req();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
